// File: rtl/rbm_gibbs_scheduler.sv
// Gibbs-iteration sequencer for the RBM datapath: drives hidden and
// classification passes per group and accumulates saturating sample counts.
module rbm_gibbs_scheduler #(
  parameter int bitlength              = 12,
  parameter int hidden_dim             = 3,
  parameter int output_dim             = 2,
  parameter int hidden_adder_group_num = 1,
  parameter int cl_adder_group_num     = 1,
  parameter int iteration_num          = 30,
  localparam int HP = (hidden_dim + hidden_adder_group_num - 1)
                      / hidden_adder_group_num,
  localparam int CP = (output_dim + cl_adder_group_num - 1)
                      / cl_adder_group_num,
  localparam int HG = (HP > 1) ? $clog2(HP) : 1,
  localparam int CG = (CP > 1) ? $clog2(CP) : 1,
  localparam int IW = $clog2(iteration_num + 1)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             data_valid,
  output logic                             h_start,
  output logic [HG-1:0]                    h_group_idx,
  input  logic                             h_done,
  output logic                             cl_start,
  output logic [CG-1:0]                    cl_group_idx,
  input  logic                             cl_done,
  input  logic [output_dim-1:0]            cl_sample,
  output logic                             seed_step,
  output logic [output_dim*bitlength-1:0]  OutputDataPort,
  output logic [IW-1:0]                    iter_count,
  output logic                             busy,
  output logic                             finish
);

  typedef enum logic [2:0] {
    IDLE, H_ISSUE, H_WAIT, C_ISSUE, C_WAIT, ITER_END, DONE
  } state_t;

  localparam logic [bitlength-1:0] INF =
    {1'b0, {(bitlength-1){1'b1}}};

  state_t state, nxt;

  logic [bitlength-1:0] cnt     [output_dim];
  logic [bitlength-1:0] cnt_inc [output_dim];

  logic h_last, c_last, i_last;
  logic h_start_n, cl_start_n, seed_step_n;
  logic busy_n, finish_n;

  assign h_last = (h_group_idx == HG'(HP - 1));
  assign c_last = (cl_group_idx == CG'(CP - 1));
  assign i_last = (iter_count == IW'(iteration_num - 1));

  // Only neurons of the active group count; the last group may be partial.
  always_comb begin
    for (int n = 0; n < output_dim; n++) begin
      cnt_inc[n] = cnt[n];
      if ((n / cl_adder_group_num) == int'(cl_group_idx)
          && cl_sample[n] && (cnt[n] != INF))
        cnt_inc[n] = cnt[n] + bitlength'(1);
    end
  end

  always_comb begin
    OutputDataPort = '0;
    for (int n = 0; n < output_dim; n++)
      OutputDataPort[n*bitlength +: bitlength] = cnt[n];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      h_start      <= 1'b0;
      cl_start     <= 1'b0;
      seed_step    <= 1'b0;
      busy         <= 1'b0;
      finish       <= 1'b0;
      h_group_idx  <= '0;
      cl_group_idx <= '0;
      iter_count   <= '0;
      for (int n = 0; n < output_dim; n++)
        cnt[n] <= '0;
    end else begin
      state     <= nxt;
      h_start   <= h_start_n;
      cl_start  <= cl_start_n;
      seed_step <= seed_step_n;
      busy      <= busy_n;
      finish    <= finish_n;
      case (state)
        IDLE: begin
          if (data_valid) begin
            h_group_idx  <= '0;
            cl_group_idx <= '0;
            iter_count   <= '0;
            for (int n = 0; n < output_dim; n++)
              cnt[n] <= '0;
          end
        end
        H_WAIT: begin
          if (h_done)
            h_group_idx <= h_last ? '0 : h_group_idx + HG'(1);
        end
        C_WAIT: begin
          if (cl_done) begin
            for (int n = 0; n < output_dim; n++)
              cnt[n] <= cnt_inc[n];
            cl_group_idx <= c_last ? '0 : cl_group_idx + CG'(1);
          end
        end
        ITER_END: iter_count <= iter_count + IW'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:     if (data_valid) nxt = H_ISSUE;
      H_ISSUE:  nxt = H_WAIT;
      H_WAIT:   if (h_done) nxt = h_last ? C_ISSUE : H_ISSUE;
      C_ISSUE:  nxt = C_WAIT;
      C_WAIT:   if (cl_done) nxt = c_last ? ITER_END : C_ISSUE;
      ITER_END: nxt = i_last ? DONE : H_ISSUE;
      DONE:     if (!data_valid) nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they emerge registered.
  always_comb begin
    h_start_n   = (nxt == H_ISSUE);
    cl_start_n  = (nxt == C_ISSUE);
    seed_step_n = (nxt == ITER_END);
    finish_n    = (nxt == DONE);
    busy_n      = (nxt != IDLE) && (nxt != DONE);
  end

endmodule

// File: tb/tb_rbm_gibbs_scheduler.sv
// Randomized scoreboard bench for rbm_gibbs_scheduler with engine responders
// that inject stray done pulses and a reference count model.
module tb_rbm_gibbs_scheduler;

  localparam int BL  = 5;
  localparam int HD  = 3;
  localparam int OD  = 3;
  localparam int HAG = 2;
  localparam int CAG = 2;
  localparam int IT  = 20;
  localparam int HP  = (HD + HAG - 1) / HAG;
  localparam int CP  = (OD + CAG - 1) / CAG;
  localparam int HG  = (HP > 1) ? $clog2(HP) : 1;
  localparam int CG  = (CP > 1) ? $clog2(CP) : 1;
  localparam int IW  = $clog2(IT + 1);
  localparam int INF = (1 << (BL - 1)) - 1;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic data_valid = 1'b0;
  logic h_start, cl_start, seed_step, busy, finish;
  logic [HG-1:0] h_group_idx;
  logic [CG-1:0] cl_group_idx;
  logic h_done = 1'b0;
  logic cl_done = 1'b0;
  logic [OD-1:0] cl_sample = '0;
  logic [OD*BL-1:0] OutputDataPort;
  logic [IW-1:0] iter_count;

  rbm_gibbs_scheduler #(
    .bitlength(BL), .hidden_dim(HD), .output_dim(OD),
    .hidden_adder_group_num(HAG), .cl_adder_group_num(CAG),
    .iteration_num(IT)
  ) dut (
    .clock(clock), .reset(reset), .data_valid(data_valid),
    .h_start(h_start), .h_group_idx(h_group_idx), .h_done(h_done),
    .cl_start(cl_start), .cl_group_idx(cl_group_idx),
    .cl_done(cl_done), .cl_sample(cl_sample),
    .seed_step(seed_step), .OutputDataPort(OutputDataPort),
    .iter_count(iter_count), .busy(busy), .finish(finish)
  );

  always #5 clock = ~clock;

  typedef struct {
    int kind;
    int idx;
    logic [OD*BL-1:0] data;
  } ev_t;

  ev_t exp_q[$];
  logic [OD-1:0] samp_q[$];
  logic [OD*BL-1:0] exp_final;
  int compared = 0;
  int mismatched = 0;

  task automatic cmp(string name, longint act, longint req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic push_ev(int kind, int idx, logic [OD*BL-1:0] d);
    ev_t e;
    e.kind = kind;
    e.idx  = idx;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Reference: count[n] = min(INF, ones of bit n over the passes of its group)
  task automatic new_run(int all_ones);
    logic [OD-1:0] s [IT*CP];
    int ones, c;
    samp_q.delete();
    exp_q.delete();
    for (int p = 0; p < IT*CP; p++) begin
      s[p] = all_ones ? '1 : OD'($urandom);
      samp_q.push_back(s[p]);
    end
    exp_final = '0;
    for (int n = 0; n < OD; n++) begin
      ones = 0;
      for (int i = 0; i < IT; i++)
        ones += int'(s[i*CP + n/CAG][n]);
      c = (ones > INF) ? INF : ones;
      exp_final[n*BL +: BL] = BL'(c);
    end
    for (int i = 0; i < IT; i++) begin
      for (int g = 0; g < HP; g++) push_ev(0, g, '0);
      for (int g = 0; g < CP; g++) push_ev(1, g, '0);
      push_ev(2, 0, '0);
    end
    push_ev(3, 0, exp_final);
  endtask

  // Monitor: every pulse the DUT presents is matched against the queue
  task automatic check_ev(int kind, int idx);
    ev_t e;
    if (exp_q.size() == 0) begin
      compared++;
      mismatched++;
      $display("FAIL unexpected_event: got kind %0d idx %0d, expected none",
               kind, idx);
    end else begin
      e = exp_q.pop_front();
      cmp("event_kind", kind, e.kind);
      cmp("group_idx", idx, e.idx);
      if (e.kind == 3) begin
        cmp("final_counts", OutputDataPort, e.data);
        cmp("final_iter_count", iter_count, IT);
        cmp("busy_at_finish", busy, 0);
      end else begin
        cmp("busy_in_run", busy, 1);
      end
    end
  endtask

  logic fin_q = 1'b0;
  always @(negedge clock) begin
    if (!reset) begin
      if (h_start)  check_ev(0, int'(h_group_idx));
      if (cl_start) check_ev(1, int'(cl_group_idx));
      if (seed_step) check_ev(2, 0);
      if (finish && !fin_q) check_ev(3, 0);
    end
    fin_q = finish;
  end

  // Engine responders: random latency, plus stray dones when idle
  int hd, cd;
  bit hp = 0;
  bit cpend = 0;
  always @(negedge clock) begin
    h_done  = 1'b0;
    cl_done = 1'b0;
    if (reset) begin
      hp    = 0;
      cpend = 0;
    end else begin
      if (h_start) begin
        hp = 1;
        hd = $urandom_range(1, 4);
      end else if (hp) begin
        hd--;
        if (hd == 0) begin
          h_done = 1'b1;
          hp = 0;
        end
      end else if ($urandom_range(0, 5) == 0) begin
        h_done = 1'b1;
      end
      if (cl_start) begin
        cpend = 1;
        cd = $urandom_range(1, 4);
      end else if (cpend) begin
        cd--;
        if (cd == 0) begin
          cl_done = 1'b1;
          cpend = 0;
          cl_sample = '0;
          if (samp_q.size() > 0) cl_sample = samp_q.pop_front();
        end
      end else if ($urandom_range(0, 5) == 0) begin
        cl_done = 1'b1;
        cl_sample = OD'($urandom);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_vals(string tag);
    cmp({tag, "_h_start"}, h_start, 0);
    cmp({tag, "_cl_start"}, cl_start, 0);
    cmp({tag, "_seed_step"}, seed_step, 0);
    cmp({tag, "_busy"}, busy, 0);
    cmp({tag, "_finish"}, finish, 0);
    cmp({tag, "_iter_count"}, iter_count, 0);
    cmp({tag, "_counts"}, OutputDataPort, 0);
    cmp({tag, "_h_idx"}, h_group_idx, 0);
    cmp({tag, "_cl_idx"}, cl_group_idx, 0);
  endtask

  task automatic wait_finish();
    int n = 0;
    while (!finish && n < 4000) begin
      tick();
      n++;
    end
    cmp("finish_within_budget", finish, 1);
  endtask

  task automatic check_launch(string tag);
    cmp({tag, "_h_start"}, h_start, 1);
    cmp({tag, "_counts_cleared"}, OutputDataPort, 0);
    cmp({tag, "_iter_cleared"}, iter_count, 0);
    cmp({tag, "_finish_low"}, finish, 0);
  endtask

  initial begin
    int n, k;
    repeat (3) tick();
    check_reset_vals("reset");
    reset = 1'b0;
    tick();

    new_run(0);
    data_valid = 1'b1;
    tick();
    check_launch("run_a");
    wait_finish();

    repeat (10) tick();
    cmp("hold_finish", finish, 1);
    cmp("hold_busy", busy, 0);
    cmp("frozen_counts", OutputDataPort, exp_final);

    data_valid = 1'b0;
    tick();
    cmp("idle_finish_low", finish, 0);
    new_run(1);
    data_valid = 1'b1;
    tick();
    check_launch("run_b");
    wait_finish();

    data_valid = 1'b0;
    tick();
    new_run(0);
    data_valid = 1'b1;
    tick();
    check_launch("run_c");
    n = 0;
    k = 0;
    while (n < 6*CP + 1 && k < 4000) begin
      tick();
      k++;
      if (cl_start) n++;
    end
    cmp("reached_iter7_c_issue", n, 6*CP + 1);
    tick();
    cmp("iter7_iter_count", iter_count, 6);
    reset = 1'b1;
    tick();
    check_reset_vals("midrun_reset");
    new_run(0);
    reset = 1'b0;
    tick();
    check_launch("run_d");
    wait_finish();

    data_valid = 1'b0;
    repeat (5) tick();
    cmp("leftover_events", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
